// File: rtl/therm_meter_pkg.sv
// Shared types and helpers for the thermometer peak meter.
//   state_t     : peak-hold FSM states (TRACK, HOLD, DECAY)
//   out_width() : bar width for a given level width (2**value_w - 1)
//   therm_of()  : thermometer code of a level, LSB-aligned, THERM_MAX_W bits;
//                 callers truncate to their own bar width
package therm_meter_pkg;

  localparam int unsigned THERM_MAX_W = 255;

  typedef enum logic [1:0] {
    TRACK = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } state_t;

  // Bar width for a level of value_w bits.
  function automatic int unsigned out_width(input int unsigned value_w);
    return (32'd1 << value_w) - 32'd1;
  endfunction

  // Bit i set iff level > i.
  function automatic logic [THERM_MAX_W-1:0] therm_of(input int unsigned level);
    logic [THERM_MAX_W-1:0] code;
    code = '0;
    for (int unsigned i = 0; i < THERM_MAX_W; i++) begin
      code[i] = (level > i);
    end
    return code;
  endfunction

endpackage

// File: rtl/therm_encode.sv
// Combinational level -> thermometer encoder.
//   level  : VALUE_W-bit unsigned level
//   code_c : OUT_W-bit thermometer code, bit i = 1 iff level > i
module therm_encode
  import therm_meter_pkg::*;
#(
  parameter int unsigned VALUE_W = 3,
  localparam int unsigned OUT_W  = out_width(VALUE_W)
) (
  input  logic [VALUE_W-1:0] level,
  output logic [OUT_W-1:0]   code_c
);

  assign code_c = OUT_W'(therm_of(32'(level)));

endmodule

// File: rtl/therm_peak_meter.sv
// Thermometer bar meter with peak-hold marker.
// Samples a level, drives a registered thermometer bar, and tracks a peak
// that is held for HOLD_CYCLES after a new peak, then decays one step every
// DECAY_CYCLES cycles until it meets the live level again.
// Optional feature: define THERM_PEAK_METER_PEAK_HOLD_EN to build the
// peak-hold FSM; without it the peak simply follows the sampled level.
// Ports:
//   clk          : clock, all state on rising edge
//   rst_n        : synchronous active-low reset
//   sample_valid : capture value this cycle
//   value        : VALUE_W-bit unsigned level
//   therm        : registered thermometer code of the last sampled level
//   peak         : current peak level
//   peak_dot     : one-hot marker, bit (peak-1); zero when peak == 0
//   holding      : high while the FSM is outside TRACK
module therm_peak_meter
  import therm_meter_pkg::*;
#(
  parameter int unsigned VALUE_W      = 3,
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned DECAY_CYCLES = 2,
  localparam int unsigned OUT_W       = out_width(VALUE_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_valid,
  input  logic [VALUE_W-1:0] value,
  output logic [OUT_W-1:0]   therm,
  output logic [VALUE_W-1:0] peak,
  output logic [OUT_W-1:0]   peak_dot,
  output logic               holding
);

  // Parameter sanity checks at elaboration.
  if (HOLD_CYCLES < 1) begin : g_hold_chk
    $error("therm_peak_meter: HOLD_CYCLES must be >= 1");
  end
  if (DECAY_CYCLES < 1) begin : g_decay_chk
    $error("therm_peak_meter: DECAY_CYCLES must be >= 1");
  end

  logic [VALUE_W-1:0] level_q;
  logic [VALUE_W-1:0] level_d;
  logic [VALUE_W-1:0] peak_d;
  logic               holding_d;
  logic [OUT_W-1:0]   therm_c;
  logic [OUT_W-1:0]   peak_code_c;

  // Level after this edge's sample; also feeds the decay-exit compare.
  assign level_d = sample_valid ? value : level_q;

  therm_encode #(.VALUE_W(VALUE_W)) u_therm_enc (
    .level  (level_d),
    .code_c (therm_c)
  );

  therm_encode #(.VALUE_W(VALUE_W)) u_peak_enc (
    .level  (peak_d),
    .code_c (peak_code_c)
  );

`ifdef THERM_PEAK_METER_PEAK_HOLD_EN

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES : DECAY_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DECAY_LOAD = CNT_W'(DECAY_CYCLES - 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic [CNT_W-1:0]   hold_cnt_d;
  logic [CNT_W-1:0]   decay_cnt_q;
  logic [CNT_W-1:0]   decay_cnt_d;
  logic [VALUE_W-1:0] peak_m1;

  // Peak-hold next-state logic.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    decay_cnt_d = decay_cnt_q;
    peak_d      = peak;
    peak_m1     = peak - VALUE_W'(1);

    if (sample_valid && (value >= peak)) begin
      // New or equal peak always (re)arms the hold, whatever the state.
      peak_d     = value;
      hold_cnt_d = HOLD_LOAD;
      state_d    = HOLD;
    end else begin
      unique case (state_q)
        TRACK: begin
          // A sample below the peak starts a hold on the current peak.
          if (sample_valid) begin
            hold_cnt_d = HOLD_LOAD;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - CNT_W'(1);
          end else begin
            decay_cnt_d = DECAY_LOAD;
            state_d     = DECAY;
          end
        end
        DECAY: begin
          if (decay_cnt_q != '0) begin
            decay_cnt_d = decay_cnt_q - CNT_W'(1);
          end else if ((peak == '0) || (peak_m1 <= level_d)) begin
            // Next step would reach the live level: snap and resume tracking.
            peak_d  = level_d;
            state_d = TRACK;
          end else begin
            peak_d      = peak_m1;
            decay_cnt_d = DECAY_LOAD;
          end
        end
        default: begin
          state_d = TRACK;
        end
      endcase
    end
  end

  assign holding_d = (state_d != TRACK);

  // FSM state and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= TRACK;
      hold_cnt_q  <= '0;
      decay_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      decay_cnt_q <= decay_cnt_d;
    end
  end

`else

  // Without peak hold the marker follows the sampled level.
  assign peak_d    = level_d;
  assign holding_d = 1'b0;

`endif

  // Output registers; the dot is the XOR of the peak code with itself
  // shifted down, leaving only bit (peak-1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q  <= '0;
      therm    <= '0;
      peak     <= '0;
      peak_dot <= '0;
      holding  <= 1'b0;
    end else begin
      level_q  <= level_d;
      therm    <= therm_c;
      peak     <= peak_d;
      peak_dot <= peak_code_c ^ (peak_code_c >> 1);
      holding  <= holding_d;
    end
  end

endmodule

// File: tb/tb_therm_peak_meter.sv
// Self-checking bench for therm_peak_meter (VALUE_W=3 main instance plus a
// VALUE_W=4 instance). Expectations adapt to THERM_PEAK_METER_PEAK_HOLD_EN.
module tb_therm_peak_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sample_valid;
  logic [2:0]  value;
  logic [3:0]  value4;
  logic [6:0]  therm;
  logic [2:0]  peak;
  logic [6:0]  peak_dot;
  logic        holding;
  logic [14:0] therm4;
  logic [3:0]  peak4;
  logic [14:0] peak_dot4;
  logic        holding4;

  therm_peak_meter #(.VALUE_W(3), .HOLD_CYCLES(4), .DECAY_CYCLES(2)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .value        (value),
    .therm        (therm),
    .peak         (peak),
    .peak_dot     (peak_dot),
    .holding      (holding)
  );

  therm_peak_meter #(.VALUE_W(4), .HOLD_CYCLES(4), .DECAY_CYCLES(2)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .value        (value4),
    .therm        (therm4),
    .peak         (peak4),
    .peak_dot     (peak_dot4),
    .holding      (holding4)
  );

  typedef struct {
    logic       rst_n;
    logic       sv;
    logic [2:0] val;
    logic [2:0] lvl;
    logic [6:0] therm;
    logic [2:0] peak;
    logic       hold;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] tl [8] = '{7'b0000000, 7'b0000001, 7'b0000011, 7'b0000111,
                         7'b0001111, 7'b0011111, 7'b0111111, 7'b1111111};

`ifdef THERM_PEAK_METER_PEAK_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  function automatic logic [6:0] dot_of(input logic [2:0] p);
    logic [6:0] r;
    r = '0;
    if (p != 3'd0) r[p - 3'd1] = 1'b1;
    return r;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // One table row; without peak hold the peak follows the level.
  task automatic add(input logic r, input logic sv, input logic [2:0] val,
                     input logic [2:0] lvl, input logic [2:0] pk, input logic hold);
    vec_t v;
    v.rst_n = r;
    v.sv    = sv;
    v.val   = val;
    v.lvl   = lvl;
    v.therm = tl[lvl];
    v.peak  = HOLD_EN ? pk : lvl;
    v.hold  = HOLD_EN ? hold : 1'b0;
    tbl.push_back(v);
  endtask

  task automatic idle(input int n, input logic [2:0] lvl, input logic [2:0] pk, input logic hold);
    for (int i = 0; i < n; i++) add(1'b1, 1'b0, 3'd0, lvl, pk, hold);
  endtask

  task automatic rst_row();
    add(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
  endtask

  // Load 5, sample 2, then idle until the first decay step (peak 4, DECAY).
  task automatic to_decay4();
    add(1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 1'b1);
    add(1'b1, 1'b1, 3'd2, 3'd2, 3'd5, 1'b1);
    idle(4, 3'd2, 3'd5, 1'b1);
    idle(1, 3'd2, 3'd4, 1'b1);
  endtask

  initial begin
    vec_t e;
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    value        = '0;
    value4       = '0;

    // Reset state
    rst_row();
    rst_row();
    // Ascending sweep
    for (int k = 0; k < 8; k++) add(1'b1, 1'b1, 3'(k), 3'(k), 3'(k), 1'b1);
    // Reset ignores a concurrent sample
    add(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 1'b0);
    // Hold then decay back to live level 2
    add(1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 1'b1);
    add(1'b1, 1'b1, 3'd2, 3'd2, 3'd5, 1'b1);
    idle(4, 3'd2, 3'd5, 1'b1);
    idle(2, 3'd2, 3'd4, 1'b1);
    idle(2, 3'd2, 3'd3, 1'b1);
    idle(2, 3'd2, 3'd2, 1'b0);
    // New peak during decay restarts a full hold
    rst_row();
    to_decay4();
    add(1'b1, 1'b1, 3'd6, 3'd6, 3'd6, 1'b1);
    add(1'b1, 1'b1, 3'd1, 3'd1, 3'd6, 1'b1);
    idle(4, 3'd1, 3'd6, 1'b1);
    idle(1, 3'd1, 3'd5, 1'b1);
    // Equal sample re-arms the hold and delays decay
    rst_row();
    add(1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 1'b1);
    add(1'b1, 1'b1, 3'd2, 3'd2, 3'd5, 1'b1);
    idle(1, 3'd2, 3'd5, 1'b1);
    add(1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 1'b1);
    add(1'b1, 1'b1, 3'd2, 3'd2, 3'd5, 1'b1);
    idle(4, 3'd2, 3'd5, 1'b1);
    idle(1, 3'd2, 3'd4, 1'b1);
    // Reset in DECAY
    rst_row();
    to_decay4();
    add(1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 1'b0);
    idle(1, 3'd0, 3'd0, 1'b0);
    add(1'b1, 1'b1, 3'd3, 3'd3, 3'd3, 1'b1);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n        = tbl[i].rst_n;
      sample_valid = tbl[i].sv;
      value        = tbl[i].val;
      value4       = '0;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      cmp("therm",    i, 32'(therm),    32'(e.therm));
      cmp("peak",     i, 32'(peak),     32'(e.peak));
      cmp("peak_dot", i, 32'(peak_dot), 32'(dot_of(e.peak)));
      cmp("holding",  i, 32'(holding),  32'(e.hold));
    end

    // Wider instance: reset, level 9, full-scale level 15
    @(negedge clk);
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    cmp("w4_reset_therm", 0, 32'(therm4), 32'd0);
    cmp("w4_reset_peak",  0, 32'(peak4),  32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    sample_valid = 1'b1;
    value        = '0;
    value4       = 4'd9;
    @(posedge clk);
    #1;
    cmp("w4_therm9",   1, 32'(therm4),    32'(15'b000000111111111));
    cmp("w4_peak9",    1, 32'(peak4),     32'd9);
    cmp("w4_dot9",     1, 32'(peak_dot4), 32'(15'b000000100000000));
    cmp("w4_holding9", 1, 32'(holding4),  32'(HOLD_EN));
    @(negedge clk);
    value4 = 4'd15;
    @(posedge clk);
    #1;
    cmp("w4_therm15", 2, 32'(therm4),    32'(15'h7fff));
    cmp("w4_peak15",  2, 32'(peak4),     32'd15);
    cmp("w4_dot15",   2, 32'(peak_dot4), 32'(15'h4000));
    @(negedge clk);
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    cmp("w4_therm_hold", 3, 32'(therm4), 32'(15'h7fff));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
